mont_exp_ctrl: RTL and testbench

- Modular exponentiation sequencer that acts as the initiator on the montgomery multiplier's start/done interface.
- Computes result = in_x^in_e mod in_m using left-to-right binary square-and-multiply in the Montgomery domain.
- Issues one multiplication at a time to an external montgomery instance and collects each product.
- Sits between the top-level/AXI register layer and the montgomery core; replaces the bench-driven start/done stimulus.

---
 rtl/mont_exp_ctrl_if.sv | 37 +++
 rtl/mont_exp_ctrl.sv | 196 +++++++++++++++++++
 tb/tb_mont_exp_ctrl.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mont_exp_ctrl_if.sv
// ============================================================================
// Module      : mont_exp_ctrl_if
// Description : Command/response bus between the exponentiation sequencer and
//               a Montgomery multiplier. The master issues one product at a
//               time with a one-cycle mm_start and waits for mm_done.
//               Signals:
//                 mm_start  - one-cycle command pulse (master -> slave)
//                 mm_a/mm_b - multiplicands, stable until mm_done (m -> s)
//                 mm_m      - odd modulus (master -> slave)
//                 mm_result - product a*b*R^-1 mod m (slave -> master)
//                 mm_done   - product valid (slave -> master)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mont_exp_ctrl_if #(
    parameter int WIDTH = 1024
);
    logic             mm_start;
    logic [WIDTH-1:0] mm_a;
    logic [WIDTH-1:0] mm_b;
    logic [WIDTH-1:0] mm_m;
    logic [WIDTH-1:0] mm_result;
    logic             mm_done;

    modport master (
        output mm_start, mm_a, mm_b, mm_m,
        input  mm_result, mm_done
    );

    modport slave (
        input  mm_start, mm_a, mm_b, mm_m,
        output mm_result, mm_done
    );
endinterface

`default_nettype wire

// File: rtl/mont_exp_ctrl.sv
// ============================================================================
// Module      : mont_exp_ctrl
// Description : Modular exponentiation sequencer, result = x^e mod m, using
//               left-to-right square-and-multiply in the Montgomery domain.
//               Drives an external Montgomery multiplier over mont_exp_ctrl_if.
//               Ports:
//                 clk, reset           - clock, async active-high reset
//                 start                - request, sampled only when idle
//                 in_x/in_e/in_m       - base, exponent, odd modulus
//                 in_r/in_r2           - R mod M and R^2 mod M, R = 2^WIDTH
//                 result/done/busy     - x^e mod m, one-cycle valid, activity
//                 mm                   - master side of the multiplier bus
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mont_exp_ctrl #(
    parameter int WIDTH  = 1024,
    parameter int E_BITS = 1024
) (
    input  wire logic              clk,
    input  wire logic              reset,
    input  wire logic              start,
    input  wire logic [WIDTH-1:0]  in_x,
    input  wire logic [E_BITS-1:0] in_e,
    input  wire logic [WIDTH-1:0]  in_m,
    input  wire logic [WIDTH-1:0]  in_r,
    input  wire logic [WIDTH-1:0]  in_r2,
    output logic      [WIDTH-1:0]  result,
    output logic                   done,
    output logic                   busy,
    mont_exp_ctrl_if.master        mm
);

    localparam int                IDX_W   = (E_BITS > 1) ? $clog2(E_BITS) : 1;
    localparam logic [IDX_W-1:0]  IDX_TOP = IDX_W'(E_BITS - 1);
    localparam logic [WIDTH-1:0]  ONE     = WIDTH'(1);

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_PRE    = 4'd1,
        S_PRE_W  = 4'd2,
        S_SQ     = 4'd3,
        S_SQ_W   = 4'd4,
        S_MUL    = 4'd5,
        S_MUL_W  = 4'd6,
        S_POST   = 4'd7,
        S_POST_W = 4'd8,
        S_DONE   = 4'd9
    } state_t;

    state_t              state_q, state_d;
    logic [WIDTH-1:0]    x_q, x_d;
    logic [E_BITS-1:0]   e_q, e_d;
    logic [WIDTH-1:0]    m_q, m_d;
    logic [WIDTH-1:0]    r2_q, r2_d;
    logic [WIDTH-1:0]    a_q, a_d;        // running accumulator (Montgomery form)
    logic [WIDTH-1:0]    xt_q, xt_d;      // base in Montgomery form
    logic [IDX_W-1:0]    idx_q, idx_d;    // exponent bit currently processed
    logic [WIDTH-1:0]    result_q, result_d;

    logic                mm_start_w;
    logic [WIDTH-1:0]    mm_a_w;
    logic [WIDTH-1:0]    mm_b_w;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            x_q      <= '0;
            e_q      <= '0;
            m_q      <= '0;
            r2_q     <= '0;
            a_q      <= '0;
            xt_q     <= '0;
            idx_q    <= IDX_TOP;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            x_q      <= x_d;
            e_q      <= e_d;
            m_q      <= m_d;
            r2_q     <= r2_d;
            a_q      <= a_d;
            xt_q     <= xt_d;
            idx_q    <= idx_d;
            result_q <= result_d;
        end
    end

    // Operand muxes depend only on the state pair (cmd, _W) and on registers
    // that update solely when leaving _W, so mm_a/mm_b hold steady while the
    // multiplier works.
    always_comb begin
        state_d    = state_q;
        x_d        = x_q;
        e_d        = e_q;
        m_d        = m_q;
        r2_d       = r2_q;
        a_d        = a_q;
        xt_d       = xt_q;
        idx_d      = idx_q;
        result_d   = result_q;
        mm_start_w = 1'b0;
        mm_a_w     = '0;
        mm_b_w     = '0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    x_d     = in_x;
                    e_d     = in_e;
                    m_d     = in_m;
                    r2_d    = in_r2;
                    a_d     = in_r;      // Montgomery form of 1
                    idx_d   = IDX_TOP;
                    state_d = S_PRE;
                end
            end
            S_PRE, S_PRE_W: begin
                mm_a_w = x_q;
                mm_b_w = r2_q;
                if (state_q == S_PRE) begin
                    mm_start_w = 1'b1;
                    state_d    = S_PRE_W;
                end else if (mm.mm_done) begin
                    xt_d    = mm.mm_result;
                    state_d = S_SQ;
                end
            end
            S_SQ, S_SQ_W: begin
                mm_a_w = a_q;
                mm_b_w = a_q;
                if (state_q == S_SQ) begin
                    mm_start_w = 1'b1;
                    state_d    = S_SQ_W;
                end else if (mm.mm_done) begin
                    a_d = mm.mm_result;
                    if (e_q[idx_q]) begin
                        state_d = S_MUL;
                    end else if (idx_q == '0) begin
                        state_d = S_POST;
                    end else begin
                        idx_d   = idx_q - 1'b1;
                        state_d = S_SQ;
                    end
                end
            end
            S_MUL, S_MUL_W: begin
                mm_a_w = a_q;
                mm_b_w = xt_q;
                if (state_q == S_MUL) begin
                    mm_start_w = 1'b1;
                    state_d    = S_MUL_W;
                end else if (mm.mm_done) begin
                    a_d = mm.mm_result;
                    if (idx_q == '0) begin
                        state_d = S_POST;
                    end else begin
                        idx_d   = idx_q - 1'b1;
                        state_d = S_SQ;
                    end
                end
            end
            S_POST, S_POST_W: begin
                // Multiplying by plain 1 strips the R factor.
                mm_a_w = a_q;
                mm_b_w = ONE;
                if (state_q == S_POST) begin
                    mm_start_w = 1'b1;
                    state_d    = S_POST_W;
                end else if (mm.mm_done) begin
                    a_d      = mm.mm_result;
                    result_d = mm.mm_result;
                    state_d  = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign mm.mm_start = mm_start_w;
    assign mm.mm_a     = mm_a_w;
    assign mm.mm_b     = mm_b_w;
    assign mm.mm_m     = m_q;
    assign result      = result_q;
    assign done        = (state_q == S_DONE);
    assign busy        = (state_q != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_mont_exp_ctrl.sv
`default_nettype none

module tb_mont_exp_ctrl;
    localparam int WIDTH  = 1024;
    localparam int E_BITS = 4;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              start = 1'b0;
    logic [WIDTH-1:0]  in_x = '0;
    logic [E_BITS-1:0] in_e = '0;
    logic [WIDTH-1:0]  in_m = '0;
    logic [WIDTH-1:0]  in_r = '0;
    logic [WIDTH-1:0]  in_r2 = '0;
    logic [WIDTH-1:0]  result;
    logic              done;
    logic              busy;

    mont_exp_ctrl_if #(.WIDTH(WIDTH)) mmif ();

    mont_exp_ctrl #(.WIDTH(WIDTH), .E_BITS(E_BITS)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .in_x   (in_x),
        .in_e   (in_e),
        .in_m   (in_m),
        .in_r   (in_r),
        .in_r2  (in_r2),
        .result (result),
        .done   (done),
        .busy   (busy),
        .mm     (mmif.slave)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    logic [WIDTH-1:0] exp_q[$];

    task automatic check(input string tag, input logic [WIDTH-1:0] obs,
                         input logic [WIDTH-1:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs[63:0], expv[63:0]);
        end
    endtask

    // Reference models: plain modular arithmetic, no Montgomery tricks.
    longint unsigned rinv = 0;

    function automatic longint unsigned mod_exp(input longint unsigned x,
                                                input logic [E_BITS-1:0] e,
                                                input longint unsigned m);
        longint unsigned acc = 1 % m;
        for (int i = E_BITS - 1; i >= 0; i--) begin
            acc = (acc * acc) % m;
            if (e[i]) acc = (acc * x) % m;
        end
        return acc;
    endfunction

    function automatic logic [WIDTH-1:0] mm_model(input logic [WIDTH-1:0] a,
                                                  input logic [WIDTH-1:0] b,
                                                  input logic [WIDTH-1:0] m);
        longint unsigned mm = m[63:0];
        longint unsigned p;
        if (mm == 0) return '0;
        p = ((a[63:0] % mm) * (b[63:0] % mm)) % mm;
        return WIDTH'((p * rinv) % mm);
    endfunction

    // Behavioural multiplier responder.
    int               lat        = 3;
    bit               alt_mode   = 1'b0;
    bit               level_mode = 1'b0;
    bit               alt_sel    = 1'b0;
    bit               pending    = 1'b0;
    int               cnt        = 0;
    logic [WIDTH-1:0] hold_res   = '0;
    logic [WIDTH-1:0] cap_a      = '0;
    logic [WIDTH-1:0] cap_b      = '0;
    int               starts_cnt = 0;
    int               stab_err   = 0;
    int               overlap_err = 0;
    int               mbad_err   = 0;
    logic [WIDTH-1:0] cur_m      = '0;

    initial begin
        mmif.mm_done   = 1'b0;
        mmif.mm_result = '0;
    end

    always @(posedge clk) begin
        if (!level_mode) mmif.mm_done <= 1'b0;
        if (mmif.mm_start) begin
            starts_cnt <= starts_cnt + 1;
            cap_a      <= mmif.mm_a;
            cap_b      <= mmif.mm_b;
            alt_sel    <= ~alt_sel;
            if (pending) overlap_err <= overlap_err + 1;
            if (mmif.mm_m !== cur_m) mbad_err <= mbad_err + 1;
            if ((alt_mode ? (alt_sel ? 37 : 1) : lat) <= 1) begin
                mmif.mm_result <= mm_model(mmif.mm_a, mmif.mm_b, mmif.mm_m);
                mmif.mm_done   <= 1'b1;
                pending        <= 1'b0;
            end else begin
                hold_res <= mm_model(mmif.mm_a, mmif.mm_b, mmif.mm_m);
                cnt      <= (alt_mode ? (alt_sel ? 37 : 1) : lat) - 1;
                pending  <= 1'b1;
            end
        end else if (pending) begin
            if (mmif.mm_a !== cap_a || mmif.mm_b !== cap_b) stab_err <= stab_err + 1;
            if (cnt == 1) begin
                mmif.mm_result <= hold_res;
                mmif.mm_done   <= 1'b1;
                pending        <= 1'b0;
            end else begin
                cnt <= cnt - 1;
            end
        end
    end

    // Scoreboard: each done pops one expected result.
    int done_cnt = 0;
    always @(negedge clk) begin
        if (done) begin
            done_cnt++;
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $error("FAIL unexpected_done: observed=1 expected=0");
            end else begin
                check("result", result, exp_q.pop_front());
            end
        end
    end

    task automatic launch(input logic [WIDTH-1:0] x, input logic [E_BITS-1:0] e,
                          input bit push);
        @(negedge clk);
        in_x  = x;
        in_e  = e;
        in_m  = 11;
        in_r  = 5;
        in_r2 = 3;
        cur_m = 11;
        start = 1'b1;
        if (push) exp_q.push_back(WIDTH'(mod_exp(x[63:0], e, 11)));
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int target, input string tag);
        int i;
        for (i = 0; i < 2000 && done_cnt < target; i++) @(negedge clk);
        check({tag, "_timeout"}, WIDTH'(done_cnt >= target), WIDTH'(1));
    endtask

    task automatic wait_starts(input int target, input string tag);
        int i;
        for (i = 0; i < 2000 && starts_cnt < target; i++) @(negedge clk);
        check({tag, "_timeout"}, WIDTH'(starts_cnt >= target), WIDTH'(1));
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_busy"},     WIDTH'(busy), '0);
        check({tag, "_done"},     WIDTH'(done), '0);
        check({tag, "_mm_start"}, WIDTH'(mmif.mm_start), '0);
        check({tag, "_mm_a"},     mmif.mm_a, '0);
        check({tag, "_mm_b"},     mmif.mm_b, '0);
        check({tag, "_mm_m"},     mmif.mm_m, '0);
        check({tag, "_result"},   result, '0);
    endtask

    int s0, d0, st0;

    initial begin
        for (longint unsigned k = 1; k < 11; k++)
            if ((5 * k) % 11 == 1) rinv = k;

        // Reset state
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_idle("reset");

        // Case 1: 3^3 mod 11 = 5
        lat = 3; s0 = starts_cnt; d0 = done_cnt; st0 = stab_err;
        launch(3, 4'b0011, 1'b1);
        wait_done(d0 + 1, "case1");
        repeat (3) @(negedge clk);
        check("case1_starts", WIDTH'(starts_cnt - s0), WIDTH'(8));
        check("case1_result_val", result, WIDTH'(5));
        check("case1_done_count", WIDTH'(done_cnt - d0), WIDTH'(1));
        check("case1_busy_after", WIDTH'(busy), '0);
        check("case1_stable", WIDTH'(stab_err - st0), '0);

        // e = 0 gives 1
        s0 = starts_cnt; d0 = done_cnt;
        launch(3, 4'b0000, 1'b1);
        wait_done(d0 + 1, "e0");
        repeat (3) @(negedge clk);
        check("e0_starts", WIDTH'(starts_cnt - s0), WIDTH'(6));
        check("e0_result_val", result, WIDTH'(1));

        // Alternating latency 1/37: 7^10 mod 11 = 1
        alt_mode = 1'b1; s0 = starts_cnt; d0 = done_cnt; st0 = stab_err;
        launch(7, 4'b1010, 1'b1);
        wait_done(d0 + 1, "alt");
        repeat (3) @(negedge clk);
        alt_mode = 1'b0;
        check("alt_starts", WIDTH'(starts_cnt - s0), WIDTH'(8));
        check("alt_result_val", result, WIDTH'(1));
        check("alt_stable", WIDTH'(stab_err - st0), '0);

        // Start pulsed during SQ_W is ignored
        lat = 5; s0 = starts_cnt; d0 = done_cnt;
        launch(3, 4'b0011, 1'b1);
        wait_starts(s0 + 2, "ign");
        @(negedge clk);
        in_x = 9; in_e = 4'b1111; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(d0 + 1, "ign");
        repeat (40) @(negedge clk);
        check("ign_starts", WIDTH'(starts_cnt - s0), WIDTH'(8));
        check("ign_done_count", WIDTH'(done_cnt - d0), WIDTH'(1));
        check("ign_result_val", result, WIDTH'(5));

        // Reset during MUL_W, then a stale mm_done arrives
        lat = 37; s0 = starts_cnt; d0 = done_cnt;
        launch(3, 4'b0011, 1'b0);
        wait_starts(s0 + 5, "rst");
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (50) @(negedge clk);
        check_idle("rst");
        check("rst_no_done", WIDTH'(done_cnt - d0), '0);
        check("rst_starts", WIDTH'(starts_cnt - s0), WIDTH'(5));

        lat = 2; d0 = done_cnt;
        launch(3, 4'b0011, 1'b1);
        wait_done(d0 + 1, "rst_fresh");
        repeat (3) @(negedge clk);
        check("rst_fresh_result_val", result, WIDTH'(5));

        // mm_done held as a level
        lat = 1; level_mode = 1'b1; s0 = starts_cnt; d0 = done_cnt;
        launch(3, 4'b0011, 1'b1);
        wait_done(d0 + 1, "lvl");
        repeat (5) @(negedge clk);
        level_mode = 1'b0;
        check("lvl_starts", WIDTH'(starts_cnt - s0), WIDTH'(8));
        check("lvl_result_val", result, WIDTH'(5));
        check("lvl_done_count", WIDTH'(done_cnt - d0), WIDTH'(1));
        check("lvl_busy_after", WIDTH'(busy), '0);

        repeat (3) @(negedge clk);
        check("overlap_errors", WIDTH'(overlap_err), '0);
        check("mm_m_errors", WIDTH'(mbad_err), '0);
        check("scoreboard_empty", WIDTH'(exp_q.size()), '0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

`default_nettype wire
